// File: rtl/joy_pkg.sv
// Shared types and constants for the joystick direction repeater.
// JOY_AUTOREPEAT_EN adds the REPEAT state to the FSM encoding.
package joy_pkg;

   localparam logic [1:0] DIR_L = 2'd0;
   localparam logic [1:0] DIR_R = 2'd1;
   localparam logic [1:0] DIR_U = 2'd2;
   localparam logic [1:0] DIR_D = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_HELD     = 2'd2
`ifdef JOY_AUTOREPEAT_EN
      ,
      ST_REPEAT   = 2'd3
`endif
   } joy_state_e;

   function automatic int unsigned max2(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   // Counter holds values up to max_cnt-1 with a spare bit, so it can never wrap.
   function automatic int unsigned cnt_width(input int unsigned max_cnt);
      return 32'($clog2(max_cnt)) + 32'd1;
   endfunction

endpackage

// File: rtl/joystick_dir_repeater_if.sv
// Sample input and button output bundle for joystick_dir_repeater.
interface joystick_dir_repeater_if #(
   parameter int unsigned ADC_W = 10
);
   logic             in_valid;
   logic [ADC_W-1:0] x_axis_in;
   logic [ADC_W-1:0] y_axis_in;
   logic [3:0]       btn_level;
   logic [3:0]       btn_pulse;

   modport master (output in_valid, x_axis_in, y_axis_in, input btn_level, btn_pulse);
   modport slave  (input in_valid, x_axis_in, y_axis_in, output btn_level, btn_pulse);
endinterface

// File: rtl/joy_dir_fsm.sv
// Per-direction debounce / hold / auto-repeat state machine.
// JOY_AUTOREPEAT_EN enables the HELD -> REPEAT path.
module joy_dir_fsm
   import joy_pkg::*;
#(
   parameter int unsigned CNT_W   = 6,
   parameter int unsigned DEB_CYC = 16
`ifdef JOY_AUTOREPEAT_EN
   ,
   parameter int unsigned REP_DLY = 500,
   parameter int unsigned REP_PER = 100
`endif
) (
   input  logic clk,
   input  logic rst,
   input  logic raw_active,
   output logic level,
   output logic pulse
);

   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYC - 1);
`ifdef JOY_AUTOREPEAT_EN
   localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REP_DLY - 1);
   localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REP_PER - 1);
`endif

   joy_state_e       state_q;
   logic [CNT_W-1:0] cnt_q;

   // Release is tested before any count compare, so it always wins over a due repeat.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         level   <= 1'b0;
         pulse   <= 1'b0;
      end else begin
         pulse <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (raw_active) begin
                  if (DEB_CYC == 1) begin
                     state_q <= ST_HELD;
                     cnt_q   <= '0;
                     level   <= 1'b1;
                     pulse   <= 1'b1;
                  end else begin
                     state_q <= ST_DEBOUNCE;
                     cnt_q   <= CNT_W'(1);
                  end
               end
            end
            ST_DEBOUNCE: begin
               if (!raw_active) begin
                  state_q <= ST_IDLE;
                  cnt_q   <= '0;
               end else if (cnt_q == DEB_LAST) begin
                  state_q <= ST_HELD;
                  cnt_q   <= '0;
                  level   <= 1'b1;
                  pulse   <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_HELD: begin
               if (!raw_active) begin
                  state_q <= ST_IDLE;
                  cnt_q   <= '0;
                  level   <= 1'b0;
               end
`ifdef JOY_AUTOREPEAT_EN
               else if (cnt_q == DLY_LAST) begin
                  state_q <= ST_REPEAT;
                  cnt_q   <= '0;
                  pulse   <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
`endif
            end
`ifdef JOY_AUTOREPEAT_EN
            ST_REPEAT: begin
               if (!raw_active) begin
                  state_q <= ST_IDLE;
                  cnt_q   <= '0;
                  level   <= 1'b0;
               end else if (cnt_q == PER_LAST) begin
                  cnt_q <= '0;
                  pulse <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
`endif
            default: begin
               state_q <= ST_IDLE;
               cnt_q   <= '0;
               level   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/joystick_dir_repeater.sv
// Two-axis joystick to four debounced direction buttons with optional auto-repeat.
// JOY_AUTOREPEAT_EN enables auto-repeat pulses while a direction is held.
module joystick_dir_repeater
   import joy_pkg::*;
#(
   parameter int unsigned ADC_W   = 10,
   parameter int unsigned TH_LOW  = 200,
   parameter int unsigned TH_HIGH = 800,
   parameter int unsigned HYST    = 32,
   parameter int unsigned DEB_CYC = 16,
   parameter int unsigned REP_DLY = 500,
   parameter int unsigned REP_PER = 100
) (
   input logic                    clk,
   input logic                    rst,
   joystick_dir_repeater_if.slave bus
);

`ifdef JOY_AUTOREPEAT_EN
   localparam int unsigned CNT_W = cnt_width(max2(DEB_CYC, max2(REP_DLY, REP_PER)));
`else
   localparam int unsigned CNT_W = cnt_width(DEB_CYC);
`endif

   localparam logic [ADC_W-1:0] MID      = {1'b1, {(ADC_W-1){1'b0}}};
   localparam logic [ADC_W-1:0] LO_PRESS = ADC_W'(TH_LOW);
   localparam logic [ADC_W-1:0] LO_REL   = ADC_W'(TH_LOW + HYST);
   localparam logic [ADC_W-1:0] HI_PRESS = ADC_W'(TH_HIGH);
   localparam logic [ADC_W-1:0] HI_REL   = ADC_W'(TH_HIGH - HYST);

   if (!(TH_LOW + 2 * HYST < TH_HIGH)) begin : g_bad_thresh
      $error("joystick_dir_repeater: need TH_LOW+HYST < TH_HIGH-HYST");
   end
   if ((ADC_W < 2) || (ADC_W > 31) || ((TH_HIGH >> ADC_W) != 0)) begin : g_bad_width
      $error("joystick_dir_repeater: need 2 <= ADC_W <= 31 and TH_HIGH < 2**ADC_W");
   end
   if ((DEB_CYC < 1) || (DEB_CYC > 65535) || (REP_DLY < 1) || (REP_PER < 1)) begin : g_bad_count
      $error("joystick_dir_repeater: count parameter out of range");
   end

   logic [ADC_W-1:0] x_q;
   logic [ADC_W-1:0] y_q;
   logic [3:0]       raw_q;
   logic [3:0]       raw_c;
   logic [3:0]       level_w;
   logic [3:0]       pulse_w;

   // Midscale reset keeps every direction inactive until real samples arrive.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_q <= MID;
         y_q <= MID;
      end else if (bus.in_valid) begin
         x_q <= bus.x_axis_in;
         y_q <= bus.y_axis_in;
      end
   end

   // Hysteresis band: between press and release thresholds the last raw state holds.
   always_comb begin
      raw_c = raw_q;
      if (x_q < LO_PRESS)       raw_c[DIR_L] = 1'b1;
      else if (x_q >= LO_REL)   raw_c[DIR_L] = 1'b0;
      if (x_q > HI_PRESS)       raw_c[DIR_R] = 1'b1;
      else if (x_q <= HI_REL)   raw_c[DIR_R] = 1'b0;
      if (y_q > HI_PRESS)       raw_c[DIR_U] = 1'b1;
      else if (y_q <= HI_REL)   raw_c[DIR_U] = 1'b0;
      if (y_q < LO_PRESS)       raw_c[DIR_D] = 1'b1;
      else if (y_q >= LO_REL)   raw_c[DIR_D] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) raw_q <= '0;
      else     raw_q <= raw_c;
   end

   for (genvar i = 0; i < 4; i++) begin : g_dir
      joy_dir_fsm #(
         .CNT_W   (CNT_W),
         .DEB_CYC (DEB_CYC)
`ifdef JOY_AUTOREPEAT_EN
         ,
         .REP_DLY (REP_DLY),
         .REP_PER (REP_PER)
`endif
      ) u_fsm (
         .clk        (clk),
         .rst        (rst),
         .raw_active (raw_c[i]),
         .level      (level_w[i]),
         .pulse      (pulse_w[i])
      );
   end

   assign bus.btn_level = level_w;
   assign bus.btn_pulse = pulse_w;

endmodule
